deflate_stage_seq: RTL and testbench

Sequencer for the per-block deflate compression pipeline. On a start request it runs three stages in fixed order, each with a start-pulse / done-pulse handshake: symbol frequency counting (`freq_list`), Huffman tree build, then code emission. It reports busy/done/error to the top-level block controller and keeps a count of completed blocks. It owns no datapath and only orders the stages.

---
 rtl/deflate_stage_seq_pkg.sv | 33 +++
 rtl/deflate_stage_seq_if.sv | 35 +++
 rtl/deflate_stage_seq_watchdog.sv | 31 +++
 rtl/deflate_stage_seq.sv | 126 ++++++++++++
 tb/tb_deflate_stage_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/deflate_stage_seq_pkg.sv
// Purpose : shared state encoding, stage codes and default widths for the deflate stage sequencer.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package deflate_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREQ   = 3'd1,
        ST_TREE   = 3'd2,
        ST_CODE   = 3'd3,
        ST_FINISH = 3'd4,
        ST_FAIL   = 3'd5
    } seq_state_t;

    // Codes driven on the `stage` output
    localparam logic [1:0] STG_IDLE = 2'd0;
    localparam logic [1:0] STG_FREQ = 2'd1;
    localparam logic [1:0] STG_TREE = 2'd2;
    localparam logic [1:0] STG_CODE = 2'd3;

    // FINISH and FAIL report as idle: no stage is running in either.
    function automatic logic [1:0] stage_of(input seq_state_t s);
        case (s)
            ST_FREQ: return STG_FREQ;
            ST_TREE: return STG_TREE;
            ST_CODE: return STG_CODE;
            default: return STG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/deflate_stage_seq_if.sv
// Purpose : block-controller and stage handshake bundle of the deflate stage sequencer.
// Latency : n/a (wires only).
// Backpressure : none; all handshakes are single-cycle pulses.
// Ports   : master = block controller / stage side, slave = sequencer side.
interface deflate_stage_seq_if #(
    parameter int ADDR_W = deflate_pkg::ADDR_W_DEF,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] block_len;
    logic              freq_start;
    logic [ADDR_W-1:0] freq_len;
    logic              freq_done;
    logic              tree_start;
    logic              tree_done;
    logic              code_start;
    logic              code_done;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        stage;
    logic [CNT_W-1:0]  blocks_done;

    modport master (
        output start, block_len, freq_done, tree_done, code_done,
        input  freq_start, freq_len, tree_start, code_start,
               busy, done, error, stage, blocks_done
    );

    modport slave (
        input  start, block_len, freq_done, tree_done, code_done,
        output freq_start, freq_len, tree_start, code_start,
               busy, done, error, stage, blocks_done
    );
endinterface

// File: rtl/deflate_stage_seq_watchdog.sv
// Purpose : per-stage cycle counter raising a timeout flag after TIMEOUT cycles in a stage.
// Latency : flag is combinational from the registered count.
// Backpressure : none.
// Ports   : clk, reset (async active-low), i_clear (stage entry/exit), i_enable (in a stage), o_timeout.
module stage_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);
    localparam int            W     = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_cnt;

    // Count holds at LIMIT so it can never wrap back under it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = i_enable && (r_cnt == LIMIT);
endmodule

// File: rtl/deflate_stage_seq.sv
// Purpose : orders freq -> tree -> code stages per block, reports busy/done/error, counts blocks.
// Latency : start -> freq_start 1 cycle; stage done -> next start 1 cycle; code_done -> done 1 cycle.
// Backpressure : start is ignored while busy; stray or early done pulses are dropped.
// Ports   : clk, reset (async active-low), bus (deflate_stage_seq_if.slave).
// Config  : DEFLATE_SEQ_WATCHDOG_EN builds the per-stage timeout and the sticky error flag.
module deflate_stage_seq
    import deflate_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    deflate_stage_seq_if.slave   bus
);
    seq_state_t        r_state, w_nxt_state;
    logic              r_freq_start, r_tree_start, r_code_start;
    logic              r_busy, r_done;
    logic [1:0]        r_stage;
    logic [ADDR_W-1:0] r_freq_len;
    logic [CNT_W-1:0]  r_blocks_done;

    logic              w_accept, w_timeout;
    logic              w_freq_start_nxt, w_tree_start_nxt, w_code_start_nxt;
    logic              w_busy_nxt, w_done_nxt;
    logic [1:0]        w_stage_nxt;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // State register; outputs are registered from their next values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_freq_start  <= 1'b0;
            r_tree_start  <= 1'b0;
            r_code_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_stage       <= STG_IDLE;
            r_freq_len    <= '0;
            r_blocks_done <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_freq_start <= w_freq_start_nxt;
            r_tree_start <= w_tree_start_nxt;
            r_code_start <= w_code_start_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_stage      <= w_stage_nxt;
            if (w_accept)
                r_freq_len <= bus.block_len;
            // Count on leaving FINISH so the new value lands with busy=0.
            if (r_state == ST_FINISH)
                r_blocks_done <= r_blocks_done + 1'b1;
        end
    end

    // Next state. A done is only taken once the stage's start pulse has passed
    // (r_*_start low); a done coincident with a timeout still completes the stage.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_nxt_state = (bus.block_len == '0) ? ST_FINISH : ST_FREQ;
            ST_FREQ:   if (bus.freq_done && !r_freq_start) w_nxt_state = ST_TREE;
                       else if (w_timeout)                 w_nxt_state = ST_FAIL;
            ST_TREE:   if (bus.tree_done && !r_tree_start) w_nxt_state = ST_CODE;
                       else if (w_timeout)                 w_nxt_state = ST_FAIL;
            ST_CODE:   if (bus.code_done && !r_code_start) w_nxt_state = ST_FINISH;
                       else if (w_timeout)                 w_nxt_state = ST_FAIL;
            ST_FINISH: w_nxt_state = ST_IDLE;
            ST_FAIL:   w_nxt_state = ST_IDLE;
            default:   w_nxt_state = ST_IDLE;
        endcase
    end

    // Output next values, decoded from the state being entered.
    always_comb begin
        w_freq_start_nxt = (w_nxt_state == ST_FREQ) && (r_state != ST_FREQ);
        w_tree_start_nxt = (w_nxt_state == ST_TREE) && (r_state != ST_TREE);
        w_code_start_nxt = (w_nxt_state == ST_CODE) && (r_state != ST_CODE);
        w_busy_nxt       = (w_nxt_state == ST_FREQ) || (w_nxt_state == ST_TREE) ||
                           (w_nxt_state == ST_CODE) || (w_nxt_state == ST_FINISH);
        w_done_nxt       = (w_nxt_state == ST_FINISH);
        w_stage_nxt      = stage_of(w_nxt_state);
    end

`ifdef DEFLATE_SEQ_WATCHDOG_EN
    logic w_in_stage;
    logic r_error;

    assign w_in_stage = (r_state == ST_FREQ) || (r_state == ST_TREE) || (r_state == ST_CODE);

    // Any state change restarts the count, so each stage gets a fresh budget.
    stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_nxt_state != r_state),
        .i_enable  (w_in_stage),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_error <= 1'b0;
        else if (w_nxt_state == ST_FAIL)
            r_error <= 1'b1;
        else if (w_accept)
            r_error <= 1'b0;
    end

    assign bus.error = r_error;
`else
    assign w_timeout = 1'b0;
    assign bus.error = 1'b0;
`endif

    assign bus.freq_start  = r_freq_start;
    assign bus.tree_start  = r_tree_start;
    assign bus.code_start  = r_code_start;
    assign bus.freq_len    = r_freq_len;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.stage       = r_stage;
    assign bus.blocks_done = r_blocks_done;
endmodule

// File: tb/tb_deflate_stage_seq.sv
// Purpose : scoreboard bench for deflate_stage_seq; stage responders answer start pulses after set delays.
// Latency : expected pulse cycles are pushed when the causing input is driven.
// Backpressure : n/a.
module tb_deflate_stage_seq;
    localparam int K_FREQ = 1, K_TREE = 2, K_CODE = 3, K_DONE = 4;

    typedef struct { int kind; int at; } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    deflate_stage_seq_if #(.ADDR_W(12), .CNT_W(16)) bus ();
    deflate_stage_seq_if #(.ADDR_W(12), .CNT_W(2))  wb  ();

    deflate_stage_seq #(.ADDR_W(12), .TIMEOUT(16), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    deflate_stage_seq #(.ADDR_W(12), .TIMEOUT(16), .CNT_W(2)) u_wrap (
        .clk(clk), .reset(reset), .bus(wb));

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_chk = 0, n_bad = 0;
    int   dly[3];
    int   due[3];
    int   exp_blocks = 0;
    int   exp_len    = 0;
    int   t_tree     = -1;
    int   t_done     = -1;
    int   got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int stg);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_pulse", kind, 0);
        end else begin
            e = sb.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_cycle", cyc, e.at);
        end
        chk("pulse_stage", bus.stage, stg);
        chk("pulse_busy", bus.busy, 1);
        chk("pulse_len", bus.freq_len, exp_len);
        if (kind == K_TREE) t_tree = cyc;
        if (kind == K_DONE) t_done = cyc;
        if (kind <= K_CODE && dly[kind-1] > 0) due[kind-1] = cyc + dly[kind-1];
    endtask

    // One cycle: drop last cycle's pulses, score output pulses, fire due stage dones.
    task automatic cyc_step();
        @(negedge clk);
        bus.start     = 1'b0;
        bus.freq_done = 1'b0;
        bus.tree_done = 1'b0;
        bus.code_done = 1'b0;
        if (bus.freq_start) observe(K_FREQ, 1);
        if (bus.tree_start) observe(K_TREE, 2);
        if (bus.code_start) observe(K_CODE, 3);
        if (bus.done)       observe(K_DONE, 0);
        if (due[0] == cyc) begin due[0] = -1; bus.freq_done = 1'b1; push(K_TREE, cyc + 1); end
        if (due[1] == cyc) begin due[1] = -1; bus.tree_done = 1'b1; push(K_CODE, cyc + 1); end
        if (due[2] == cyc) begin
            due[2] = -1; bus.code_done = 1'b1; push(K_DONE, cyc + 1); exp_blocks++;
        end
    endtask

    task automatic drive_start(input int len);
        logic [11:0] l;
        l = 12'(len);
        bus.start     = 1'b1;
        bus.block_len = l;
        exp_len       = len;
        if (len == 0) begin push(K_DONE, cyc + 1); exp_blocks++; end
        else          push(K_FREQ, cyc + 1);
    endtask

    task automatic run_to_idle(input string tag);
        int fin;
        fin = 0;
        for (int i = 0; i < 300 && fin == 0; i++) begin
            cyc_step();
            if (!bus.busy && sb.size() == 0) begin
                fin = 1;
                chk(tag, bus.blocks_done, 32'(exp_blocks));
            end
        end
        if (fin == 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 want 1");
        $fatal(1);
    end

    initial begin
        bus.start = 0; bus.block_len = '0;
        bus.freq_done = 0; bus.tree_done = 0; bus.code_done = 0;
        wb.start = 0; wb.block_len = '0;
        wb.freq_done = 0; wb.tree_done = 0; wb.code_done = 0;
        due = '{-1, -1, -1};
        dly = '{5, 5, 5};

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {bus.freq_start, bus.tree_start, bus.code_start,
                         bus.busy, bus.done, bus.error, bus.stage}, 0);
        chk("rst_cnt", bus.blocks_done, 0);
        chk("rst_len", bus.freq_len, 0);
        reset = 1'b1;

        // Nominal block: start in cycle 10 -> pulses 11/17/23, done 29
        while (cyc < 10) cyc_step();
        drive_start(100);
        run_to_idle("nom_blocks");
        chk("nom_done_at", t_done, 29);

        // Empty block: done next cycle, no stage pulses
        cyc_step();
        drive_start(0);
        run_to_idle("empty_blocks");

        // Stray inputs during FREQ, including a freq_done on the start-pulse cycle
        dly = '{8, 5, 5};
        cyc_step();
        drive_start(100);
        cyc_step();
        chk("spur_stage0", bus.stage, 1);
        bus.start = 1'b1; bus.block_len = 12'd7; bus.freq_done = 1'b1;
        cyc_step();
        bus.tree_done = 1'b1;
        cyc_step();
        bus.code_done = 1'b1;
        cyc_step();
        chk("spur_stage", bus.stage, 1);
        chk("spur_len", bus.freq_len, 100);
        chk("spur_busy", bus.busy, 1);
        run_to_idle("spur_blocks");

        // Withheld tree_done
        dly = '{3, 0, 3};
        cyc_step();
        t_tree = -1;
        drive_start(50);
        for (int i = 0; i < 50 && t_tree < 0; i++) cyc_step();
        chk("tree_seen", (t_tree >= 0), 1);
`ifdef DEFLATE_SEQ_WATCHDOG_EN
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            cyc_step();
            if (bus.error) got = 1;
        end
        chk("wd_seen", got, 1);
        chk("wd_at", cyc, t_tree + 17);
        chk("wd_busy", bus.busy, 0);
        chk("wd_blocks", bus.blocks_done, 32'(exp_blocks));
        cyc_step();
        chk("wd_sticky", bus.error, 1);
        drive_start(0);
        cyc_step();
        chk("wd_clear", bus.error, 0);
        run_to_idle("wd_after_blocks");
`else
        repeat (40) cyc_step();
        chk("nowd_stage", bus.stage, 2);
        chk("nowd_busy", bus.busy, 1);
        chk("nowd_error", bus.error, 0);
        bus.tree_done = 1'b1;
        push(K_CODE, cyc + 1);
        run_to_idle("nowd_blocks");
`endif

        // Asynchronous reset while in CODE
        dly = '{2, 2, 20};
        cyc_step();
        drive_start(33);
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            cyc_step();
            if (bus.stage == 2'd3) got = 1;
        end
        chk("reach_code", got, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_ctrl", {bus.freq_start, bus.tree_start, bus.code_start,
                          bus.busy, bus.done, bus.error, bus.stage}, 0);
        chk("arst_cnt", bus.blocks_done, 0);
        chk("arst_len", bus.freq_len, 0);
        sb.delete();
        due = '{-1, -1, -1};
        exp_blocks = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dly = '{5, 5, 5};
        cyc_step();
        drive_start(100);
        run_to_idle("post_rst_blocks");

        // 2-bit counter wraps: 5 blocks -> 1
        for (int b = 0; b < 5; b++) begin
            @(negedge clk); wb.start = 1'b1; wb.block_len = '0;
            @(negedge clk); wb.start = 1'b0;
            @(negedge clk);
        end
        chk("wrap_cnt", wb.blocks_done, 1);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
